// File: rtl/decode_stage.sv
// Registered RV decode stage with a one-cycle load-use bubble and saturating stall counter.
// Optional macro DECODE_ILLEGAL_DETECT_EN flags unknown opcodes and squashes their enables.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [31:0]      io_in_instruction,
    input  logic [XLEN-1:0]  io_in_pc,
    input  logic             io_flush,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [XLEN-1:0]  io_out_pc,
    output logic [4:0]       io_out_reg1_read_address,
    output logic [4:0]       io_out_reg2_read_address,
    output logic [XLEN-1:0]  io_out_immediate,
    output logic             io_out_aluop1_source,
    output logic             io_out_aluop2_source,
    output logic             io_out_memory_read_enable,
    output logic             io_out_memory_write_enable,
    output logic             io_out_reg_write_enable,
    output logic [1:0]       io_out_wb_reg_write_source,
    output logic [4:0]       io_out_reg_write_address,
    output logic             io_out_illegal,
    output logic [CNT_W-1:0] io_stall_count,
    output logic [1:0]       io_debug_state
);
    // Handshake: a word moves across a port in any cycle where valid and ready are both high
    // at the rising edge; valid never depends on ready, and a held bundle stays stable until taken.

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_FULL   = 2'd1,
        S_BUBBLE = 2'd2
    } state_t;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_OP     = 7'h33;

    state_t      state;
    logic        load_pending;
    logic [4:0]  load_rd;

    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic        is_op_imm, is_load, is_jalr, is_store, is_branch;
    logic        is_lui, is_auipc, is_jal, is_op, known;

    logic [31:0]     imm32;
    logic [XLEN-1:0] d_imm;
    logic [4:0]      d_rs1;
    logic            d_a1, d_a2, d_mr, d_mw, d_we, d_illegal;
    logic [1:0]      d_wb;

    logic rs1_used, rs2_used, hazard, out_fire, accept;

    assign ins       = io_in_instruction;
    assign opcode    = ins[6:0];
    assign rs1       = ins[19:15];
    assign rs2       = ins[24:20];
    assign rd        = ins[11:7];
    assign is_op_imm = (opcode == OPC_OP_IMM);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_op     = (opcode == OPC_OP);
    assign known     = is_op_imm | is_load | is_jalr | is_store | is_branch
                     | is_lui | is_auipc | is_jal | is_op;

    always_comb begin
        imm32 = {{20{ins[31]}}, ins[31:20]};
        if (is_store)
            imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        else if (is_branch)
            imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        else if (is_lui || is_auipc)
            imm32 = {ins[31:12], 12'b0};
        else if (is_jal)
            imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    end

    assign d_imm = XLEN'($signed(imm32));

    always_comb begin
        d_rs1 = is_lui ? 5'd0 : rs1;
        d_a1  = is_auipc | is_branch | is_jal;
        d_a2  = ~is_op;
        d_mr  = is_load;
        d_mw  = is_store;
        d_we  = is_op | is_op_imm | is_load | is_auipc | is_lui | is_jal | is_jalr;
        d_wb  = 2'd0;
        if (is_load)
            d_wb = 2'd1;
        else if (is_jal || is_jalr)
            d_wb = 2'd3;
`ifdef DECODE_ILLEGAL_DETECT_EN
        d_illegal = ~known;
        if (!known) begin
            d_mr = 1'b0;
            d_mw = 1'b0;
            d_we = 1'b0;
        end
`else
        d_illegal = 1'b0;
`endif
    end

    // Source registers only count when the opcode actually reads them.
    assign rs1_used = ~(is_lui | is_auipc | is_jal);
    assign rs2_used = is_op | is_store | is_branch;

    assign io_out_valid   = (state == S_FULL);
    assign io_debug_state = state;
    assign out_fire       = io_out_valid && io_out_ready;

    // A bundle that stays held already separates the load from its consumer, so no bubble then.
    assign hazard = load_pending && io_in_valid && (state != S_BUBBLE)
                 && (!io_out_valid || io_out_ready)
                 && ((rs1_used && (rs1 != 5'd0) && (rs1 == load_rd))
                  || (rs2_used && (rs2 != 5'd0) && (rs2 == load_rd)));

    assign io_in_ready = !reset && (io_flush
                      || ((state != S_BUBBLE) && (!io_out_valid || io_out_ready) && !hazard));
    assign accept = io_in_valid && io_in_ready && !io_flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            state                      <= S_EMPTY;
            load_pending               <= 1'b0;
            load_rd                    <= 5'd0;
            io_stall_count             <= '0;
            io_out_pc                  <= '0;
            io_out_reg1_read_address   <= 5'd0;
            io_out_reg2_read_address   <= 5'd0;
            io_out_immediate           <= '0;
            io_out_aluop1_source       <= 1'b0;
            io_out_aluop2_source       <= 1'b0;
            io_out_memory_read_enable  <= 1'b0;
            io_out_memory_write_enable <= 1'b0;
            io_out_reg_write_enable    <= 1'b0;
            io_out_wb_reg_write_source <= 2'd0;
            io_out_reg_write_address   <= 5'd0;
            io_out_illegal             <= 1'b0;
        end else begin
            load_pending <= out_fire && io_out_memory_read_enable
                         && (io_out_reg_write_address != 5'd0) && !io_flush;
            load_rd      <= io_out_reg_write_address;
            if (io_flush) begin
                state <= S_EMPTY;
            end else if (hazard) begin
                state <= S_BUBBLE;
                if (io_stall_count != '1)
                    io_stall_count <= io_stall_count + 1'b1;
            end else if (state == S_BUBBLE) begin
                state <= S_EMPTY;
            end else if (accept) begin
                state                      <= S_FULL;
                io_out_pc                  <= io_in_pc;
                io_out_reg1_read_address   <= d_rs1;
                io_out_reg2_read_address   <= rs2;
                io_out_immediate           <= d_imm;
                io_out_aluop1_source       <= d_a1;
                io_out_aluop2_source       <= d_a2;
                io_out_memory_read_enable  <= d_mr;
                io_out_memory_write_enable <= d_mw;
                io_out_reg_write_enable    <= d_we;
                io_out_wb_reg_write_source <= d_wb;
                io_out_reg_write_address   <= rd;
                io_out_illegal             <= d_illegal;
            end else if (out_fire) begin
                state <= S_EMPTY;
            end
        end
    end

endmodule
